seg_scan: RTL and testbench

Display scanner that sits directly downstream of segReg and owns its 8-bit command bus (in[7:0] = {position[2:0], load, data[3:0]}). It walks the eight digit positions, reads each stored segment pattern from segReg and drives one-hot digit enables for a multiplexed 8-digit seven-segment display. Host writes enter through a request/acknowledge port and are slotted onto the same bus between scan reads, so segReg has exactly one master.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_onehot.sv | 27 ++
 rtl/seg_scan.sv | 121 ++++++++++++
 tb/tb_seg_scan.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner.
// Holds the scan FSM state type, the segReg command bus field offsets and
// the helper that yields the "all digits off" anode value for a polarity.
package seg_pkg;

  typedef enum logic [1:0] {
    StBlank,
    StRead,
    StCapt,
    StShow
  } scan_state_e;

  // Command bus layout: {pos[2:0], load, data[3:0]}
  localparam int unsigned POS_MSB  = 7;
  localparam int unsigned POS_LSB  = 5;
  localparam int unsigned LOAD_BIT = 4;
  localparam int unsigned DATA_MSB = 3;

  function automatic logic [7:0] an_off(input bit active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/seg_onehot.sv
// 3-bit to 8-bit one-hot digit-enable decoder with selectable polarity.
// Ports:
//   pos_i    digit position to light
//   en_i     1: drive one-hot of pos_i, 0: all digits off
//   onehot_o digit enables (active-low when ACTIVE_LOW=1)
module seg_onehot
  import seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [2:0] pos_i,
  input  logic       en_i,
  output logic [7:0] onehot_o
);

  logic [7:0] hot;

  always_comb begin
    hot = 8'h01 << pos_i;
    if (en_i) begin
      onehot_o = ACTIVE_LOW ? ~hot : hot;
    end else begin
      onehot_o = an_off(ACTIVE_LOW);
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed 8-digit seven-segment scanner and sole master of segReg.
// Walks positions 0..7: BLANK (ghost suppression) -> READ (issue read) ->
// CAPT (latch reg_out) -> SHOW (light digit). Host writes are slotted onto
// the shared command bus during BLANK and SHOW, never stalling the scan.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   en                scan enable (0 blanks display, holds position)
//   wr_req/pos/data   host write request, held until wr_ack
//   wr_ack            write granted this cycle (combinational)
//   reg_in / reg_out  segReg command bus / segment pattern return
//   seg, an           segment drive and digit enables
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned DIV_W         = 4,
  parameter int unsigned BLANK_CYC     = 2,
  parameter bit          AN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_req,
  input  logic [2:0] wr_pos,
  input  logic [3:0] wr_data,
  output logic       wr_ack,
  output logic [7:0] reg_in,
  input  logic [7:0] reg_out,
  output logic [7:0] seg,
  output logic [7:0] an
);

  localparam int unsigned BlankW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int unsigned CntW   = (DIV_W > BlankW) ? DIV_W : BlankW;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'((2 ** DIV_W) - 1);

  scan_state_e     state_q, state_d;
  logic [2:0]      pos_q, pos_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      seg_q, seg_d;
  logic            grant;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBlank;
      pos_q   <= 3'd0;
      cnt_q   <= '0;
      seg_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    // reg_out answers the READ command one cycle later, i.e. during CAPT
    if (state_q == StCapt) begin
      seg_d = reg_out;
    end
    if (!en) begin
      state_d = StBlank;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StRead;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StRead: state_d = StCapt;
        StCapt: state_d = StShow;
        StShow: begin
          if (cnt_q == ShowLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            pos_d   = pos_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StBlank;
      endcase
    end
  end

  // Outputs. rst_n gates the grant so a reset mid-write drops wr_ack and
  // load immediately, even while the FSM already sits in BLANK.
  always_comb begin
    grant  = rst_n && wr_req && ((state_q == StBlank) || (state_q == StShow));
    wr_ack = grant;
    reg_in = 8'h00;
    if (grant) begin
      reg_in[POS_MSB:POS_LSB] = wr_pos;
      reg_in[LOAD_BIT]        = 1'b1;
      reg_in[DATA_MSB:0]      = wr_data;
    end else begin
      reg_in[POS_MSB:POS_LSB] = pos_q;
    end
    seg = seg_q;
  end

  seg_onehot #(
    .ACTIVE_LOW (AN_ACTIVE_LOW)
  ) u_onehot (
    .pos_i    (pos_q),
    .en_i     (state_q == StShow),
    .onehot_o (an)
  );

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with a behavioural segReg alongside.
module tb_seg_scan;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       wr_req;
  logic [2:0] wr_pos;
  logic [3:0] wr_data;
  logic       wr_ack;
  logic [7:0] reg_in;
  logic [7:0] reg_out;
  logic [7:0] seg;
  logic [7:0] an;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  seg_scan #(
    .DIV_W         (4),
    .BLANK_CYC     (2),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .wr_req  (wr_req),
    .wr_pos  (wr_pos),
    .wr_data (wr_data),
    .wr_ack  (wr_ack),
    .reg_in  (reg_in),
    .reg_out (reg_out),
    .seg     (seg),
    .an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // segReg model: preload 8'h10+pos while in reset; a write stores {4'h2, nibble}
  logic [7:0] mem [8];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h10 + 8'(i);
    end else if (reg_in[4]) begin
      mem[reg_in[7:5]] <= {4'h2, reg_in[3:0]};
    end
    reg_out <= mem[reg_in[7:5]];
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic goto_cyc(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic logic [7:0] an_exp(input int p);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << p);
  endfunction

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    wr_req  = 1'b1;
    wr_pos  = 3'd1;
    wr_data = 4'h5;
    reg_out = 8'h00;

    // Reset, with a write request pending
    repeat (3) @(negedge clk);
    check_eq("rst_an", an, 8'hFF);
    check_eq("rst_seg", seg, 8'h00);
    check_eq("rst_ack", {7'b0, wr_ack}, 8'h00);
    check_eq("rst_load", {7'b0, reg_in[4]}, 8'h00);
    wr_req = 1'b0;

    // Release at a negedge: this is cycle 0 (BLANK cnt 0)
    rst_n = 1'b1;
    cyc   = 0;
    goto_cyc(2);
    check_eq("first_read_bus", reg_in, 8'h00);
    check_eq("first_read_an", an, 8'hFF);
    goto_cyc(3);
    check_eq("capt_an", an, 8'hFF);

    // Scan order over one full frame and the wrap
    for (int p = 0; p < 8; p++) begin
      goto_cyc(4 + 20 * p);
      check_eq($sformatf("scan_an%0d", p), an, an_exp(p));
      check_eq($sformatf("scan_seg%0d", p), seg, 8'h10 + 8'(p));
    end
    goto_cyc(19);
    goto_cyc(164);
    check_eq("wrap_an", an, 8'hFE);
    check_eq("wrap_seg", seg, 8'h10);

    // Write during SHOW of pos 0
    goto_cyc(170);
    wr_req = 1'b1; wr_pos = 3'd5; wr_data = 4'hA;
    #1;
    check_eq("show_wr_ack", {7'b0, wr_ack}, 8'h01);
    check_eq("show_wr_bus", reg_in, 8'hBA);
    goto_cyc(171);
    wr_req = 1'b0;
    #1;
    check_eq("show_wr_idle", reg_in, 8'h00);
    goto_cyc(180);
    check_eq("show_wr_blank", an, 8'hFF);
    goto_cyc(184);
    check_eq("show_wr_timing", an, 8'hFD);
    goto_cyc(264);
    check_eq("show_wr_an5", an, 8'hDF);
    check_eq("show_wr_seg5", seg, 8'h2A);

    // Collision: request raised on the READ cycle of pos 0
    goto_cyc(322);
    wr_req = 1'b1; wr_pos = 3'd2; wr_data = 4'h3;
    #1;
    check_eq("col_read_ack", {7'b0, wr_ack}, 8'h00);
    check_eq("col_read_bus", reg_in, 8'h00);
    goto_cyc(323);
    #1;
    check_eq("col_capt_ack", {7'b0, wr_ack}, 8'h00);
    check_eq("col_capt_bus", reg_in, 8'h00);
    goto_cyc(324);
    #1;
    check_eq("col_show_ack", {7'b0, wr_ack}, 8'h01);
    check_eq("col_show_bus", reg_in, 8'h53);
    check_eq("col_show_an", an, 8'hFE);
    check_eq("col_show_seg", seg, 8'h10);
    goto_cyc(325);
    wr_req = 1'b0;

    // Enable drop mid-SHOW of pos 3, with a write to pos 3 while blanked
    goto_cyc(390);
    en = 1'b0;
    #1;
    check_eq("en_drop_same", an, 8'hF7);
    goto_cyc(391);
    check_eq("en_drop_next", an, 8'hFF);
    wr_req = 1'b1; wr_pos = 3'd3; wr_data = 4'h7;
    #1;
    check_eq("en_off_ack", {7'b0, wr_ack}, 8'h01);
    check_eq("en_off_bus", reg_in, 8'h77);
    goto_cyc(392);
    wr_req = 1'b0;
    goto_cyc(440);
    check_eq("en_off_hold", an, 8'hFF);
    check_eq("en_off_bus_idle", reg_in, 8'h60);
    en = 1'b1;
    goto_cyc(442);
    check_eq("en_on_read", reg_in, 8'h60);
    goto_cyc(443);
    check_eq("en_on_capt", an, 8'hFF);
    goto_cyc(444);
    check_eq("en_on_an", an, 8'hF7);
    check_eq("en_on_seg", seg, 8'h27);

    // Async reset during a granted write, well away from the rising edge
    goto_cyc(450);
    wr_req = 1'b1; wr_pos = 3'd1; wr_data = 4'h5;
    #1;
    check_eq("arst_pre_ack", {7'b0, wr_ack}, 8'h01);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ack", {7'b0, wr_ack}, 8'h00);
    check_eq("arst_load", {7'b0, reg_in[4]}, 8'h00);
    check_eq("arst_an", an, 8'hFF);
    check_eq("arst_seg", seg, 8'h00);
    wr_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
